// File: rtl/bitserial_logic_unit.sv
// bitserial_logic_unit
//   Bit-serial bitwise logic unit. Computes OR / AND / XOR / NOR of two
//   WIDTH-bit operands one bit per clock, LSB first. The result is built by
//   shifting each new bit into the MSB of the result register.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous, active-high reset
//   start  in   1      operation request; sampled only in IDLE or DONE
//   op     in   2      00 OR, 01 AND, 10 XOR, 11 NOR; sampled with start
//   in1    in   WIDTH  operand A; sampled with start
//   in2    in   WIDTH  operand B; sampled with start
//   busy   out  1      high exactly while an operation is running
//   done   out  1      one-cycle pulse; out/zero are valid while it is high
//   out    out  WIDTH  result register; holds until the next operation shifts
//   zero   out  1      last result was all zeros; updated on entry to DONE
//
// Handshake: start is an accept-when-idle request. It is taken on any edge
// where the unit is in IDLE or DONE (there is no ready signal; busy low means
// the next edge will accept). done is a one-cycle valid with no back-pressure:
// the consumer must capture out/zero that cycle or read out later from IDLE.
// start while busy is dropped, not queued.

module bitserial_logic_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // State is kept as a named enum so checkers can bind to it directly.
  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] cnt;

  logic             res_bit;
  logic [WIDTH-1:0] next_out;

  always_comb begin
    res_bit = 1'b0;
    case (op_q)
      2'b00:   res_bit = a_q[0] | b_q[0];
      2'b01:   res_bit = a_q[0] & b_q[0];
      2'b10:   res_bit = a_q[0] ^ b_q[0];
      default: res_bit = ~(a_q[0] | b_q[0]);
    endcase
    next_out = {res_bit, out[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= 2'b00;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      out   <= '0;
      zero  <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          out <= next_out;
          a_q <= a_q >> 1;
          b_q <= b_q >> 1;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            // Last bit: zero is taken from the completed result word.
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            zero  <= (next_out == '0);
          end
        end

        // IDLE and DONE accept identically, which gives back-to-back issue.
        default: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= in1;
            b_q   <= in2;
            op_q  <= op;
            cnt   <= '0;
            state <= S_RUN;
            busy  <= 1'b1;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bitserial_logic_unit.sv
module tb_bitserial_logic_unit;

  localparam int WIDTH = 8;
  localparam int CNT_W = 3;

  logic             clk;
  logic             rst;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             zero;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  bitserial_logic_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .in1   (in1),
    .in2   (in2),
    .busy  (busy),
    .done  (done),
    .out   (out),
    .zero  (zero)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Operation-level view: an accepted request produces its whole-word result
  // WIDTH edges later; the unit can accept again on the edge after that.
  function automatic logic [WIDTH-1:0] ref_op(input logic [1:0] o,
                                              input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
    case (o)
      2'b00:   return x | y;
      2'b01:   return x & y;
      2'b10:   return x ^ y;
      default: return ~(x | y);
    endcase
  endfunction

  logic [WIDTH-1:0] exp_q[$];
  int               m_left;
  logic             m_done;
  logic [WIDTH-1:0] m_out;
  logic             m_zero;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left = 0;
      m_done = 1'b0;
      m_out  = '0;
      m_zero = 1'b0;
      exp_q.delete();
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      m_done = (m_left == 0);
      if (m_done) begin
        m_out  = exp_q.pop_front();
        m_zero = (m_out == '0);
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        exp_q.push_back(ref_op(op, in1, in2));
        m_left = WIDTH;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model; out is only meaningful outside RUN.
  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", 32'(busy), 32'(m_left > 0));
      chk("done", 32'(done), 32'(m_done));
      chk("zero", 32'(zero), 32'(m_zero));
      if (m_left == 0) chk("out", 32'(out), 32'(m_out));
      if (done) done_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic s, input logic [1:0] o,
                       input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    start = s;
    op    = o;
    in1   = x;
    in2   = y;
  endtask

  // Issue one operation, wait for done, check latency and literal result.
  task automatic do_op(input string name, input logic [1:0] o,
                       input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                       input logic [WIDTH-1:0] exp_out, input logic exp_zero);
    int n;
    @(posedge clk); #1;
    drive(1'b1, o, x, y);
    @(posedge clk); #1;             // accept edge
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_lat"}, 32'(n), 32'(WIDTH));
    chk({name, "_out"}, 32'(out), 32'(exp_out));
    chk({name, "_zero"}, 32'(zero), 32'(exp_zero));
    chk({name, "_model"}, 32'(m_out), 32'(exp_out));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int d0;
    int last_e;
    int hits;
    rst = 1'b1;
    drive(1'b0, 2'b00, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_out",  32'(out),  32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    rst = 1'b0;

    // Directed operations with hand-computed results.
    do_op("or",    2'b00, 8'hA5, 8'h0F, 8'hAF, 1'b0);
    do_op("and",   2'b01, 8'hF0, 8'h3C, 8'h30, 1'b0);
    do_op("xor",   2'b10, 8'hFF, 8'h0F, 8'hF0, 1'b0);
    do_op("nor",   2'b11, 8'hFF, 8'h00, 8'h00, 1'b1);
    do_op("or01",  2'b00, 8'h01, 8'h00, 8'h01, 1'b0);

    // start during RUN is ignored, and changing inputs has no effect.
    @(posedge clk); #1;
    drive(1'b1, 2'b00, 8'h12, 8'h21);
    @(posedge clk); #1;             // edge 0: accepted
    start = 1'b0;
    d0 = done_seen;
    repeat (2) @(posedge clk);
    #1;
    drive(1'b1, 2'b01, 8'hFF, 8'h21);
    @(posedge clk); #1;             // edge 3: ignored
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ign_out", 32'(out), 32'h33);
    repeat (15) @(posedge clk);
    #1;
    chk("ign_pulses", 32'(done_seen - d0), 32'd1);

    // Asynchronous reset mid-RUN clears everything immediately.
    do_op("nor2", 2'b11, 8'hFF, 8'h00, 8'h00, 1'b1);
    @(posedge clk); #1;
    drive(1'b1, 2'b00, 8'hFF, 8'h00);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_out",  32'(out),  32'd0);
    chk("arst_zero", 32'(zero), 32'd0);
    @(posedge clk); #3;
    rst = 1'b0;
    do_op("post_rst", 2'b10, 8'h3C, 8'h0F, 8'h33, 1'b0);

    // start held high: back-to-back results every WIDTH+1 edges.
    @(posedge clk); #1;
    drive(1'b1, 2'b10, 8'hAA, 8'h55);
    n = 0;
    hits = 0;
    last_e = -1;
    while (hits < 3 && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (done) begin
        chk("b2b_out", 32'(out), 32'hFF);
        if (last_e >= 0) chk("b2b_period", 32'(n - last_e), 32'(WIDTH + 1));
        last_e = n;
        hits++;
      end
    end
    start = 1'b0;
    chk("b2b_count", 32'(hits), 32'd3);
    repeat (12) @(posedge clk);

    // Randomized traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      drive($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)),
            8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 149) == 0) begin
        #2;
        rst = 1'b1;
        @(posedge clk); #3;
        rst = 1'b0;
      end
    end
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
